// File: rtl/mem_write_monitor_pkg.sv
// Shared types and constants for the data-memory write monitor.
package mem_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mon_state_t;

  localparam int WCNT_W = 16;
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  // Index width that stays legal for a single-entry table.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_monitor_exp_table.sv
// Expected (address, data) table: register file with write decode and
// combinational read port, cleared by the asynchronous reset.
module exp_table
  import mem_mon_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NEXP  = 4,
  localparam int IW   = idx_w(NEXP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IW-1:0]    widx,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    ridx,
  output logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] ent_addr [NEXP];
  logic [WIDTH-1:0] ent_data [NEXP];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NEXP; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else if (we && (int'(widx) < NEXP)) begin
      ent_addr[widx] <= waddr;
      ent_data[widx] <= wdata;
    end
  end

  // Indices past the populated depth read as zero.
  always_comb begin
    raddr = '0;
    rdata = '0;
    if (int'(ridx) < NEXP) begin
      raddr = ent_addr[ridx];
      rdata = ent_data[ridx];
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// In-order checker for the core's data-memory write port against a
// programmable expected-write table, with ignore address and timeout.
//
// state | meaning
// IDLE  | after reset, waiting for start; all outputs 0
// RUN   | checking writes in order, timeout timer running
// PASS  | all active entries matched; sticky until start/reset
// FAIL  | mismatch (strict) or timeout; sticky until start/reset
module mem_write_monitor
  import mem_mon_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NEXP    = 4,
  parameter int TIMEOUT = 1024,
  parameter int STRICT  = 1,
  localparam int IW     = idx_w(NEXP),
  localparam int CW     = $clog2(NEXP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [WIDTH-1:0]  cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic [CW-1:0]     cfg_num,
  input  logic              ign_en,
  input  logic [WIDTH-1:0]  ign_addr,
  input  logic              memwrite,
  input  logic [WIDTH-1:0]  dataadr,
  input  logic [WIDTH-1:0]  writedata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CW-1:0]     match_cnt,
  output logic [WCNT_W-1:0] write_cnt,
  output logic [WIDTH-1:0]  err_addr,
  output logic [WIDTH-1:0]  err_data
);

  localparam int TW            = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] NUM_MAX  = CW'(NEXP);
  localparam bit STRICT_B      = (STRICT != 0);

  mon_state_t       state;
  logic [CW-1:0]    num_q;
  logic [TW-1:0]    tmr;
  logic [WIDTH-1:0] exp_addr;
  logic [WIDTH-1:0] exp_data;

  logic [CW-1:0]     num_clamped;
  logic [CW-1:0]     match_nxt;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              wr_run;
  logic              is_ign;
  logic              is_match;
  logic              is_miss;

  exp_table #(
    .WIDTH (WIDTH),
    .NEXP  (NEXP)
  ) u_exp_table (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we && (state != RUN)),
    .widx  (cfg_idx),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .ridx  (match_cnt[IW-1:0]),
    .raddr (exp_addr),
    .rdata (exp_data)
  );

  always_comb begin
    num_clamped = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
    match_nxt   = match_cnt + 1'b1;
    wcnt_inc    = (write_cnt == WCNT_MAX) ? write_cnt : write_cnt + 1'b1;
    wr_run      = (state == RUN) && memwrite;
    is_ign      = ign_en && (dataadr == ign_addr);
    is_match    = wr_run && !is_ign && (dataadr == exp_addr) && (writedata == exp_data);
    is_miss     = wr_run && !is_ign && !is_match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      num_q     <= '0;
      tmr       <= '0;
      match_cnt <= '0;
      write_cnt <= '0;
      err_addr  <= '0;
      err_data  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else if (start) begin
      // Restart from any state; a write in this cycle is never checked.
      num_q     <= num_clamped;
      tmr       <= TMR_LOAD;
      match_cnt <= '0;
      write_cnt <= '0;
      err_addr  <= '0;
      err_data  <= '0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      if (num_clamped == '0) begin
        state <= PASS;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else begin
        state <= RUN;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
          if (is_match) begin
            match_cnt <= match_nxt;
            write_cnt <= wcnt_inc;
          end
          if (is_miss) write_cnt <= wcnt_inc;

          // Completion outranks a mismatch and a timeout on the same edge.
          if (is_match && (match_nxt == num_q)) begin
            state <= PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (is_miss && STRICT_B) begin
            state    <= FAIL;
            done     <= 1'b1;
            fail     <= 1'b1;
            err_addr <= dataadr;
            err_data <= writedata;
          end else if (tmr == '0) begin
            state   <= FAIL;
            done    <= 1'b1;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Self-checking bench: strict and tolerant monitors side by side, directed
// vectors for the documented scenarios plus randomized runs vs. a model.
module tb_mem_write_monitor;

  localparam int TMO = 16;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [2:0]  mc;
    logic [15:0] wc;
    logic [31:0] ea;
    logic [31:0] ed;
  } outs_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    outs_t       es;
    outs_t       et;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [2:0]  cfg_num = '0;
  logic        ign_en = 1'b0;
  logic [31:0] ign_addr = '0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;

  logic s_done, s_pass, s_fail, s_timeout;
  logic t_done, t_pass, t_fail, t_timeout;
  logic [2:0]  s_mc, t_mc;
  logic [15:0] s_wc, t_wc;
  logic [31:0] s_ea, s_ed, t_ea, t_ed;
  outs_t s_o, t_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] tab_a [4];
  logic [31:0] tab_d [4];

  always #5 clk = ~clk;

  mem_write_monitor #(.WIDTH(32), .NEXP(4), .TIMEOUT(TMO), .STRICT(1)) u_strict (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_num(cfg_num), .ign_en(ign_en),
    .ign_addr(ign_addr), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
    .match_cnt(s_mc), .write_cnt(s_wc), .err_addr(s_ea), .err_data(s_ed)
  );

  mem_write_monitor #(.WIDTH(32), .NEXP(4), .TIMEOUT(TMO), .STRICT(0)) u_tol (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_num(cfg_num), .ign_en(ign_en),
    .ign_addr(ign_addr), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(t_done), .pass(t_pass), .fail(t_fail), .timeout(t_timeout),
    .match_cnt(t_mc), .write_cnt(t_wc), .err_addr(t_ea), .err_data(t_ed)
  );

  assign s_o = {s_done, s_pass, s_fail, s_timeout, s_mc, s_wc, s_ea, s_ed};
  assign t_o = {t_done, t_pass, t_fail, t_timeout, t_mc, t_wc, t_ea, t_ed};

  function automatic outs_t mk(input logic dn, input logic ps, input logic fl, input logic to,
                               input int mc, input int wc, input int ea, input int ed);
    outs_t o;
    o.done = dn; o.pass = ps; o.fail = fl; o.timeout = to;
    o.mc = 3'(mc); o.wc = 16'(wc); o.ea = 32'(ea); o.ed = 32'(ed);
    return o;
  endfunction

  // Reference: walk the expected list with a pointer, one sampled cycle at a time.
  function automatic outs_t model_step(input outs_t o, input bit strict, input int t,
                                       input logic we, input logic [31:0] a,
                                       input logic [31:0] d, input int n);
    if (o.done) return o;
    if (we && !(ign_en && a == ign_addr)) begin
      if (o.wc != 16'hFFFF) o.wc = o.wc + 16'd1;
      if (a == tab_a[o.mc[1:0]] && d == tab_d[o.mc[1:0]]) begin
        o.mc = o.mc + 3'd1;
        if (int'(o.mc) == n) begin
          o.done = 1'b1; o.pass = 1'b1;
          return o;
        end
      end else if (strict) begin
        o.done = 1'b1; o.fail = 1'b1; o.ea = a; o.ed = d;
        return o;
      end
    end
    if (t == TMO - 1) begin
      o.done = 1'b1; o.fail = 1'b1; o.timeout = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_o(input string nm, input outs_t a, input outs_t e);
    chk({nm, ".done"}, 32'(a.done), 32'(e.done));
    chk({nm, ".pass"}, 32'(a.pass), 32'(e.pass));
    chk({nm, ".fail"}, 32'(a.fail), 32'(e.fail));
    chk({nm, ".timeout"}, 32'(a.timeout), 32'(e.timeout));
    chk({nm, ".match_cnt"}, 32'(a.mc), 32'(e.mc));
    chk({nm, ".write_cnt"}, 32'(a.wc), 32'(e.wc));
    chk({nm, ".err_addr"}, a.ea, e.ea);
    chk({nm, ".err_data"}, a.ed, e.ed);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    tab_a[idx] = a; tab_d[idx] = d;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1; cfg_num = 3'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_o("reset_s", s_o, '0);
    chk_o("reset_t", t_o, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin tab_a[i] = '0; tab_d[i] = '0; end
  endtask

  vec_t vt [4];

  initial begin
    outs_t m_s, m_t, z;
    z = '0;

    vt[0] = '{1'b1, 32'd80, 32'd1, mk(0,0,0,0,1,1,0,0),   mk(0,0,0,0,1,1,0,0)};
    vt[1] = '{1'b1, 32'd90, 32'd0, mk(1,0,1,0,1,2,90,0),  mk(0,0,0,0,1,2,0,0)};
    vt[2] = '{1'b1, 32'd84, 32'd2, mk(1,0,1,0,1,2,90,0),  mk(0,0,0,0,2,3,0,0)};
    vt[3] = '{1'b1, 32'd88, 32'd3, mk(1,0,1,0,1,2,90,0),  mk(1,1,0,0,3,4,0,0)};

    repeat (2) @(posedge clk);
    do_reset();
    tick();
    chk_o("idle_s", s_o, z);

    // Single entry with an ignored neighbouring store.
    load(0, 32'd84, 32'd7);
    ign_en = 1'b1; ign_addr = 32'd82;
    pulse_start(1);
    chk_o("single_start_s", s_o, z);
    store(32'd82, 32'd5);
    chk_o("single_ign_s", s_o, z);
    chk_o("single_ign_t", t_o, z);
    store(32'd84, 32'd7);
    chk_o("single_pass_s", s_o, mk(1,1,0,0,1,1,0,0));
    chk_o("single_pass_t", t_o, mk(1,1,0,0,1,1,0,0));
    ign_en = 1'b0;

    pulse_start(0);
    chk_o("num0_s", s_o, mk(1,1,0,0,0,0,0,0));
    chk_o("num0_t", t_o, mk(1,1,0,0,0,0,0,0));

    // Timeout exactly TMO cycles after RUN is entered.
    pulse_start(1);
    idle(TMO - 1);
    chk_o("tmo_pre_s", s_o, z);
    tick();
    chk_o("tmo_s", s_o, mk(1,0,1,1,0,0,0,0));
    chk_o("tmo_t", t_o, mk(1,0,1,1,0,0,0,0));
    pulse_start(1);
    idle(TMO - 1);
    store(32'd84, 32'd7);
    chk_o("tmo_last_s", s_o, mk(1,1,0,0,1,1,0,0));
    chk_o("tmo_last_t", t_o, mk(1,1,0,0,1,1,0,0));

    // Table-driven sequence, strict and tolerant side by side.
    load(0, 32'd80, 32'd1);
    load(1, 32'd84, 32'd2);
    load(2, 32'd88, 32'd3);
    pulse_start(3);
    for (int i = 0; i < 4; i++) begin
      memwrite = vt[i].we; dataadr = vt[i].a; writedata = vt[i].d;
      tick();
      memwrite = 1'b0;
      chk_o($sformatf("vec%0d_s", i), s_o, vt[i].es);
      chk_o($sformatf("vec%0d_t", i), t_o, vt[i].et);
    end

    // Strict mismatch, starting from FAIL.
    pulse_start(3);
    chk_o("restart_s", s_o, z);
    store(32'd80, 32'd1);
    store(32'd84, 32'd9);
    chk_o("strict_miss_s", s_o, mk(1,0,1,0,1,2,84,9));
    chk_o("strict_miss_t", t_o, mk(0,0,0,0,1,2,0,0));

    // Start coinciding with a matching store: restart only.
    memwrite = 1'b1; dataadr = 32'd80; writedata = 32'd1;
    pulse_start(3);
    memwrite = 1'b0;
    chk_o("start_wr_s", s_o, z);
    chk_o("start_wr_t", t_o, z);
    store(32'd80, 32'd1);
    chk_o("resume_s", s_o, mk(0,0,0,0,1,1,0,0));

    // Table writes during RUN are dropped.
    load(1, 32'd84, 32'd5);
    tab_d[1] = 32'd2;
    store(32'd84, 32'd2);
    chk_o("cfg_run_s", s_o, mk(0,0,0,0,2,2,0,0));
    chk_o("cfg_run_t", t_o, mk(0,0,0,0,2,2,0,0));

    // Reset mid-RUN clears outputs at once and empties the table.
    do_reset();
    pulse_start(1);
    store(32'd80, 32'd1);
    chk_o("cleared_s", s_o, mk(1,0,1,0,0,1,80,1));
    chk_o("cleared_t", t_o, mk(0,0,0,0,0,1,0,0));

    // Randomized runs against the reference model.
    do_reset();
    for (int r = 0; r < 30; r++) begin
      int nraw, n, gp;
      nraw = int'($urandom_range(0, 7));
      n = (nraw > 4) ? 4 : nraw;
      for (int i = 0; i < 4; i++)
        load(i, 32'h80 + 32'(4 * $urandom_range(0, 5)), 32'($urandom_range(0, 3)));
      ign_en = 1'($urandom_range(0, 1));
      ign_addr = 32'h80 + 32'(4 * $urandom_range(0, 5));
      pulse_start(nraw);
      m_s = (n == 0) ? mk(1,1,0,0,0,0,0,0) : z;
      m_t = m_s;
      chk_o($sformatf("rnd%0d_start_s", r), s_o, m_s);
      chk_o($sformatf("rnd%0d_start_t", r), t_o, m_t);
      gp = 0;
      for (int t = 0; t < TMO + 2; t++) begin
        int kind;
        logic we;
        logic [31:0] a, d;
        kind = int'($urandom_range(0, 9));
        we = 1'b1;
        d = 32'($urandom_range(0, 3));
        if (kind < 6 && gp < 4) begin
          a = tab_a[gp]; d = tab_d[gp]; gp++;
        end else if (kind < 8) begin
          a = ign_addr;
        end else if (kind < 9) begin
          a = 32'h80 + 32'(4 * $urandom_range(0, 5));
        end else begin
          we = 1'b0; a = '0;
        end
        memwrite = we; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
        m_s = model_step(m_s, 1'b1, t, we, a, d, n);
        m_t = model_step(m_t, 1'b0, t, we, a, d, n);
        chk_o($sformatf("rnd%0d_c%0d_s", r, t), s_o, m_s);
        chk_o($sformatf("rnd%0d_c%0d_t", r, t), t_o, m_t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesisable monitor for the data-memory write port of the pipelined MIPS core. It is the parametrised successor to the single fixed-address check:
- holds a programmable table of up to NEXP expected (address, data) writes;
- masks one programmable "don't-care" address;
- checks writes in order, in strict or tolerant mode;
- reports pass / fail / timeout as registered status.

It sits beside `mipstop` on `memwrite`/`dataadr`/`writedata`, so benches and on-board self-test share one checker.

## Interface
Parameters:
- WIDTH, 32, address and data width
- NEXP, 4, expected-table depth (≥1)
- TIMEOUT, 1024, RUN cycles before timeout failure (≥1)
- STRICT, 1, 1 = any non-ignored, non-matching write fails; 0 = non-matching writes counted and tolerated

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- start  in  1  one-cycle pulse: clear counters, enter RUN
- cfg_we  in  1  write expected entry; honoured only outside RUN
- cfg_idx  in  $clog2(NEXP) (min 1)  entry index
- cfg_addr  in  WIDTH  expected address
- cfg_data  in  WIDTH  expected data
- cfg_num  in  $clog2(NEXP+1)  active entries, sampled on start, values >NEXP clamp to NEXP
- ign_en  in  1  enable ignore address
- ign_addr  in  WIDTH  address whose writes are never checked
- memwrite  in  1  core store strobe
- dataadr  in  WIDTH  store address
- writedata  in  WIDTH  store data
- done  out  1  in PASS or FAIL
- pass  out  1  all cfg_num entries matched
- fail  out  1  mismatch or timeout
- timeout  out  1  fail caused by timeout
- match_cnt  out  $clog2(NEXP+1)  entries matched so far
- write_cnt  out  16  non-ignored writes seen in RUN, saturating at 16'hFFFF
- err_addr  out  WIDTH  dataadr of first failing write (0 on timeout)
- err_data  out  WIDTH  writedata of first failing write (0 on timeout)

## Operation
- States: IDLE, RUN, PASS, FAIL.
- All outputs are 0 in reset and IDLE.
- Table entries reset to 0.
- **start (any state):** go to RUN; clear match_cnt, write_cnt, the cycle counter, err_* and all flags; latch cfg_num. If the latched cfg_num is 0, go to PASS instead.
- **Write classification in RUN, per cycle with memwrite=1:**
  - Ignored: ign_en && dataadr==ign_addr. Ignore wins over a table match. No counters change.
  - Match: {dataadr, writedata} equals entry[match_cnt]. Increment match_cnt and write_cnt. If the new match_cnt equals cfg_num, go to PASS.
  - Mismatch: increment write_cnt.
    - STRICT=1: go to FAIL and capture err_addr/err_data.
    - STRICT=0: stay in RUN.
- **Timeout:** the cycle counter increments every RUN cycle. When it reaches TIMEOUT-1 without completion, go to FAIL with timeout=1 and err_* = 0.
- **PASS / FAIL:** sticky until start or reset. Writes are ignored and counters frozen.
- **cfg_we during RUN:** dropped; the table is unchanged.

## Timing
- start sampled at edge k → state RUN visible after edge k; writes presented in the start cycle are not checked.
- A write sampled at edge k → match_cnt, write_cnt, pass, fail, err_* updated after edge k (one-cycle latency, all registered).
- Completing match and timeout on the same edge → PASS wins; timeout=0.
- start while memwrite=1 → restart only; that write is not checked.
- start asserted for multiple cycles → each cycle restarts; checking begins the cycle after start falls.
- reset asserted mid-RUN → immediate IDLE with all outputs 0. The table is cleared and must be reloaded.
- cfg_we and start in the same cycle → the table write takes effect; the start latches the new cfg_num but checks against the entry as it was before the edge. Benches must not rely on this ordering.

## Structure
- Package `mem_mon_pkg`:
  - state enum `mon_state_t` {IDLE, RUN, PASS, FAIL};
  - localparam for the write_cnt width (16).
- Sub-module `exp_table`:
  - NEXP×(2·WIDTH) register array;
  - synchronous write, combinational read by match_cnt;
  - async active-low clear.
- FSM, counters and comparison live in `mem_write_monitor`.

## Test plan
- **Single entry:** table {84, 7}, cfg_num=1, ign_addr=82 enabled. Stores 82←5, then 84←7 → pass=1 one cycle after the 84 store; write_cnt=1, match_cnt=1.
- **Strict mismatch:** NEXP=4, STRICT=1, entries {80,1},{84,2},{88,3}. Stores 80←1, 84←9 → fail=1 with err_addr=84, err_data=9, match_cnt=1.
- **Tolerant mode:** STRICT=0, same table. Stores 80←1, 90←0, 84←2, 88←3 → pass=1; write_cnt=4, match_cnt=3.
- **Timeout:** TIMEOUT=16, cfg_num=1, no stores → fail=1 and timeout=1 exactly 16 cycles after RUN is entered. A variant with the matching store on the final cycle → pass=1, timeout=0.
- **Restart, reset and boundaries:**
  - pulse start while in FAIL → counters and flags cleared, RUN resumes;
  - drop reset mid-RUN → all outputs 0 immediately;
  - cfg_num=0 → pass=1 one cycle after start;
  - cfg_we during RUN → table unchanged.
